// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_types_pkg                                                    |
// | Shared CPU word and RAM handshake types.                         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package cpu_types_pkg;

  localparam int c_WORD_W = 32;

  typedef logic [c_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter                                                      |
// | Single-port RAM arbiter between icache and dcache with data      |
// | priority bounded by a starvation limit, timeout and abort.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_WAIT   = 15,
  parameter int STARVE_LIM = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                iREN,
  input  logic [c_WORD_W-1:0] iaddr,
  output logic                iwait,
  output logic [c_WORD_W-1:0] iload,
  input  logic                dREN,
  input  logic                dWEN,
  input  logic [c_WORD_W-1:0] daddr,
  input  logic [c_WORD_W-1:0] dstore,
  output logic                dwait,
  output logic [c_WORD_W-1:0] dload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [c_WORD_W-1:0] ramaddr,
  output logic [c_WORD_W-1:0] ramstore,
  input  logic [c_WORD_W-1:0] ramload,
  input  ramstate_t           ramstate,
  output logic                err
);

  localparam int c_WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam int c_SCW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [c_WCW-1:0] c_WAIT_LAST  = c_WCW'(MAX_WAIT - 1);
  localparam logic [c_SCW-1:0] c_STARVE_TOP = c_SCW'(STARVE_LIM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DACC = 2'd1,
    S_IACC = 2'd2
  } arbState_t;

  arbState_t        r_state;
  arbState_t        w_next;
  logic [c_WCW-1:0] r_waitCnt;
  logic [c_SCW-1:0] r_starveCnt;
  logic             w_dReq;
  logic             w_starved;
  logic             w_fail;
  logic             w_grant;

  assign w_dReq    = dREN | dWEN;
  assign w_starved = iREN && (r_starveCnt == c_STARVE_TOP);
  // This cycle is the last one allowed without ACCESS, or RAM reported a fault.
  assign w_fail    = (ramstate == ERROR) ||
                     ((ramstate != ACCESS) && (r_waitCnt == c_WAIT_LAST));
  assign w_grant   = (r_state == S_IDLE) && (w_dReq || iREN);

  always_comb begin
    w_next   = r_state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dReq && !w_starved) begin
          w_next = S_DACC;
        end else if (iREN) begin
          w_next = S_IACC;
        end
      end
      S_DACC: begin
        if (!w_dReq) begin
          w_next = S_IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          // A zero wait count only occurs in the first cycle of an access.
          if (dREN && dWEN && (r_waitCnt == '0)) begin
            err = 1'b1;
          end
          if (ramstate == ACCESS) begin
            dwait  = 1'b0;
            dload  = dWEN ? '0 : ramload;
            w_next = S_IDLE;
          end else if (w_fail) begin
            dwait  = 1'b0;
            err    = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      S_IACC: begin
        if (!iREN) begin
          w_next = S_IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            iwait  = 1'b0;
            iload  = ramload;
            w_next = S_IDLE;
          end else if (w_fail) begin
            iwait  = 1'b0;
            err    = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_waitCnt   <= '0;
      r_starveCnt <= '0;
    end else begin
      if (w_grant) begin
        r_waitCnt <= '0;
      end else if ((r_state != S_IDLE) && (ramstate != ACCESS) &&
                   (r_waitCnt != c_WAIT_LAST)) begin
        r_waitCnt <= r_waitCnt + c_WCW'(1);
      end
      if (r_state == S_IDLE) begin
        if (!iREN || (w_next == S_IACC)) begin
          r_starveCnt <= '0;
        end else if ((w_next == S_DACC) && (r_starveCnt != c_STARVE_TOP)) begin
          r_starveCnt <= r_starveCnt + c_SCW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter                                                   |
// | Directed and randomized checks of mem_arbiter against a          |
// | transaction-level reference model.                               |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int MAX_WAIT   = 15;
  localparam int STARVE_LIM = 2;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  ramstate_t   ramstate;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .STARVE_LIM(STARVE_LIM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the RAM (0 none, 1 data, 2 instr), how many
  // cycles of the current access have elapsed, consecutive data wins over a waiting icache.
  int mOwner = 0, mAge = 0, mStreak = 0;
  int eNext, eStreak;
  logic        eREN, eWEN, eIwait, eDwait, eErr;
  logic [31:0] eAddr, eStore, eIload, eDload;

  logic        oREN, oWEN, oIwait, oDwait, oErr;
  logic [31:0] oAddr, oStore, oIload, oDload;
  int dwaitLows = 0, iwaitLows = 0;
  bit logGrants = 0;
  int dutGrants[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    bit timedOut;
    eREN = 0; eWEN = 0; eAddr = 0; eStore = 0;
    eIwait = 1; eDwait = 1; eIload = 0; eDload = 0; eErr = 0;
    eNext = mOwner; eStreak = mStreak;
    timedOut = (ramstate == ERROR) || (mAge + 1 >= MAX_WAIT);
    if (RST) begin
      eNext = 0; eStreak = 0;
    end else if (mOwner == 0) begin
      if ((dREN || dWEN) && !(iREN && mStreak == STARVE_LIM)) eNext = 1;
      else if (iREN) eNext = 2;
      else eNext = 0;
      if (!iREN || eNext == 2) eStreak = 0;
      else if (eNext == 1) eStreak = (mStreak + 1 > STARVE_LIM) ? STARVE_LIM : mStreak + 1;
    end else if (mOwner == 1) begin
      if (!(dREN || dWEN)) eNext = 0;
      else begin
        eWEN = dWEN; eREN = dREN && !dWEN; eAddr = daddr; eStore = dstore;
        eErr = (mAge == 0) && dREN && dWEN;
        if (ramstate == ACCESS) begin
          eDwait = 0; eDload = dWEN ? 32'h0 : ramload; eNext = 0;
        end else if (timedOut) begin
          eDwait = 0; eErr = 1; eNext = 0;
        end
      end
    end else begin
      if (!iREN) eNext = 0;
      else begin
        eREN = 1; eAddr = iaddr;
        if (ramstate == ACCESS) begin
          eIwait = 0; eIload = ramload; eNext = 0;
        end else if (timedOut) begin
          eIwait = 0; eErr = 1; eNext = 0;
        end
      end
    end
  endtask

  // One clock cycle: predict from current inputs, compare mid-cycle, advance.
  task automatic tick();
    predict();
    @(negedge CLK);
    oREN = ramREN; oWEN = ramWEN; oAddr = ramaddr; oStore = ramstore;
    oIwait = iwait; oDwait = dwait; oIload = iload; oDload = dload; oErr = err;
    check("ramREN",   32'(oREN),   32'(eREN));
    check("ramWEN",   32'(oWEN),   32'(eWEN));
    check("ramaddr",  oAddr,       eAddr);
    check("ramstore", oStore,      eStore);
    check("iwait",    32'(oIwait), 32'(eIwait));
    check("dwait",    32'(oDwait), 32'(eDwait));
    check("iload",    oIload,      eIload);
    check("dload",    oDload,      eDload);
    check("err",      32'(oErr),   32'(eErr));
    if (!oDwait) dwaitLows++;
    if (!oIwait) iwaitLows++;
    if (logGrants && (oREN || oWEN)) dutGrants.push_back((oAddr == 32'h2000) ? 1 : 2);
    @(posedge CLK);
    #1;
    if (mOwner == 0 && eNext != 0) mAge = 0;
    else if (eNext != 0) mAge++;
    mOwner = eNext;
    mStreak = eStreak;
  endtask

  task automatic idleInputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
  endtask

  initial begin
    int n;
    bit found;
    int expOrder[6];
    idleInputs();
    RST = 1;
    @(posedge CLK);
    #1;

    // Reset state, including requests present while in reset
    tick();
    dREN = 1; iREN = 1; ramstate = ACCESS;
    tick();
    check("rst_dwait", 32'(oDwait), 32'd1);
    check("rst_ramREN", 32'(oREN), 32'd0);
    idleInputs();
    RST = 0;
    tick();

    // Data read, two BUSY cycles, then ACCESS
    dwaitLows = 0;
    dREN = 1; daddr = 32'h40; ramstate = BUSY; ramload = 32'hDEADBEEF;
    tick();
    tick();
    check("rd_addr", oAddr, 32'h40);
    tick();
    ramstate = ACCESS;
    tick();
    check("rd_dwait", 32'(oDwait), 32'd0);
    check("rd_dload", oDload, 32'hDEADBEEF);
    dREN = 0; ramstate = FREE;
    tick();
    check("rd_once", 32'(dwaitLows), 32'd1);

    // Data write
    dWEN = 1; daddr = 32'h80; dstore = 32'h12345678; ramstate = ACCESS;
    tick();
    tick();
    check("wr_ramWEN", 32'(oWEN), 32'd1);
    check("wr_ramREN", 32'(oREN), 32'd0);
    check("wr_store", oStore, 32'h12345678);
    check("wr_dwait", 32'(oDwait), 32'd0);
    dWEN = 0;
    tick();

    // Read+write together: treated as write, err only on first access cycle
    dREN = 1; dWEN = 1; daddr = 32'h90; dstore = 32'hA5A5A5A5; ramstate = BUSY;
    tick();
    tick();
    check("rw_err_first", 32'(oErr), 32'd1);
    check("rw_ramWEN", 32'(oWEN), 32'd1);
    ramstate = ACCESS;
    tick();
    check("rw_err_done", 32'(oErr), 32'd0);
    check("rw_dload", oDload, 32'h0);
    idleInputs();
    tick();

    // Grant order under continuous contention
    iREN = 1; dREN = 1; iaddr = 32'h1000; daddr = 32'h2000; ramstate = ACCESS;
    ramload = 32'h0BADF00D;
    logGrants = 1;
    dutGrants.delete();
    for (int k = 0; k < 12; k++) tick();
    logGrants = 0;
    expOrder = '{1, 1, 2, 1, 1, 2};
    check("order_len", 32'(dutGrants.size()), 32'd6);
    for (int k = 0; k < 6 && k < dutGrants.size(); k++)
      check("order_owner", 32'(dutGrants[k]), 32'(expOrder[k]));
    idleInputs();
    tick();

    // Icache read stuck BUSY times out
    iREN = 1; iaddr = 32'h300; ramstate = BUSY; ramload = 32'hFFFFFFFF;
    tick();
    n = 0; found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      tick();
      if (!oIwait) begin found = 1; n = k; end
    end
    check("to_cycle", 32'(n), 32'd15);
    check("to_err", 32'(oErr), 32'd1);
    check("to_iload", oIload, 32'h0);
    tick();
    check("to_idle_ren", 32'(oREN), 32'd0);
    idleInputs();
    tick();

    // RAM ERROR on the first data cycle
    dREN = 1; daddr = 32'h44; ramstate = ERROR; ramload = 32'h11111111;
    tick();
    tick();
    check("ramerr_dwait", 32'(oDwait), 32'd0);
    check("ramerr_err", 32'(oErr), 32'd1);
    check("ramerr_dload", oDload, 32'h0);
    idleInputs();
    tick();

    // Abort: dREN dropped mid-BUSY
    dwaitLows = 0;
    dREN = 1; daddr = 32'h50; ramstate = BUSY;
    tick();
    tick();
    dREN = 0;
    tick();
    check("abort_ren", 32'(oREN), 32'd0);
    check("abort_err", 32'(oErr), 32'd0);
    tick();
    check("abort_nowait", 32'(dwaitLows), 32'd0);

    // Asynchronous reset in the middle of a data access
    dREN = 1; daddr = 32'h60; ramstate = BUSY; ramload = 32'h5555AAAA;
    tick();
    tick();
    check("pre_rst_ren", 32'(oREN), 32'd1);
    RST = 1;
    #1;
    check("async_ren", 32'(ramREN), 32'd0);
    check("async_addr", ramaddr, 32'h0);
    check("async_dwait", 32'(dwait), 32'd1);
    tick();
    RST = 0;
    ramstate = ACCESS;
    tick();
    tick();
    check("post_rst_dload", oDload, 32'h5555AAAA);
    idleInputs();
    tick();

    // Randomized traffic, sticky requests
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 20) iREN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 20) dREN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 15) dWEN = ($urandom_range(0, 99) < 30);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      n = $urandom_range(0, 99);
      ramstate = (n < 40) ? ACCESS : (n < 85) ? BUSY : (n < 95) ? FREE : ERROR;
      tick();
    end

    // Randomized slow RAM to exercise timeouts
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) < 3) iREN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3) dREN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3) dWEN = 1'($urandom_range(0, 1));
      daddr = $urandom; iaddr = $urandom; ramload = $urandom;
      ramstate = ($urandom_range(0, 99) < 2) ? ACCESS : BUSY;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
